// File: rtl/branch_resolve_queue_pkg.sv
// Shared types and defaults for the branch predictor blocks.
package branch_resolve_queue_pkg;

  localparam int unsigned BRQ_DEPTH = 8;

  typedef struct packed {
    logic        valid;
    logic        resolved;
    logic [31:0] pc;
    logic        pred;
    logic        taken;
  } brq_entry_t;

endpackage

// File: rtl/branch_resolve_queue.sv
// In-order branch resolve queue feeding predictor updates; stats counters are
// built only when BRQ_STATS_EN is defined.
module branch_resolve_queue
  import branch_resolve_queue_pkg::*;
#(
  parameter int unsigned DEPTH = BRQ_DEPTH,
  parameter int unsigned TAG_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_valid,
  input  logic [31:0]      alloc_pc,
  input  logic             alloc_pred,
  output logic             alloc_ready,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             resolve_valid,
  input  logic [TAG_W-1:0] resolve_tag,
  input  logic             resolve_taken,
  input  logic             flush,
  output logic             upd_valid,
  output logic [31:0]      upd_pc,
  output logic             upd_taken,
  output logic             upd_mispredict
`ifdef BRQ_STATS_EN
  ,
  output logic [31:0]      stat_branches,
  output logic [31:0]      stat_mispredicts
`endif
);

  localparam logic [TAG_W:0] FullCount = (TAG_W + 1)'(DEPTH);

  brq_entry_t       r_entries [DEPTH];
  logic [TAG_W-1:0] r_head;
  logic [TAG_W-1:0] r_tail;
  logic [TAG_W:0]   r_count;
  logic             r_upd_valid;
  logic [31:0]      r_upd_pc;
  logic             r_upd_taken;
  logic             r_upd_mispredict;

  brq_entry_t       w_head_entry;
  logic [TAG_W-1:0] w_head_nxt;
  logic             w_alloc;
  logic             w_retire;
  logic             w_mispredict;
  logic             w_resolve;

  assign alloc_ready  = (r_count < FullCount);
  assign alloc_tag    = r_tail;
  assign w_head_entry = r_entries[r_head];
  assign w_head_nxt   = r_head + 1'b1;
  assign w_alloc      = alloc_valid && alloc_ready;
  assign w_retire     = w_head_entry.valid && w_head_entry.resolved;
  assign w_mispredict = w_retire && (w_head_entry.pred != w_head_entry.taken);
  assign w_resolve    = resolve_valid && r_entries[resolve_tag].valid &&
                        !r_entries[resolve_tag].resolved;

  assign upd_valid      = r_upd_valid;
  assign upd_pc         = r_upd_pc;
  assign upd_taken      = r_upd_taken;
  assign upd_mispredict = r_upd_mispredict;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_entries[i] <= '0;
      end
      r_head           <= '0;
      r_tail           <= '0;
      r_count          <= '0;
      r_upd_valid      <= 1'b0;
      r_upd_pc         <= '0;
      r_upd_taken      <= 1'b0;
      r_upd_mispredict <= 1'b0;
    end else if (flush) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_entries[i].valid    <= 1'b0;
        r_entries[i].resolved <= 1'b0;
      end
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_upd_valid <= 1'b0;
    end else begin
      r_upd_valid <= w_retire;
      if (w_retire) begin
        r_upd_pc         <= w_head_entry.pc;
        r_upd_taken      <= w_head_entry.taken;
        r_upd_mispredict <= w_mispredict;
      end
      if (w_mispredict) begin
        // Everything younger than the mispredicted head is on the wrong path.
        for (int i = 0; i < int'(DEPTH); i++) begin
          r_entries[i].valid    <= 1'b0;
          r_entries[i].resolved <= 1'b0;
        end
        r_head  <= w_head_nxt;
        r_tail  <= w_head_nxt;
        r_count <= '0;
      end else begin
        if (w_retire) begin
          r_entries[r_head].valid    <= 1'b0;
          r_entries[r_head].resolved <= 1'b0;
          r_head                     <= w_head_nxt;
        end
        if (w_alloc) begin
          r_entries[r_tail] <= '{valid: 1'b1, resolved: 1'b0, pc: alloc_pc,
                                 pred: alloc_pred, taken: 1'b0};
          r_tail            <= r_tail + 1'b1;
        end
        if (w_resolve) begin
          r_entries[resolve_tag].resolved <= 1'b1;
          r_entries[resolve_tag].taken    <= resolve_taken;
        end
        if (w_alloc && !w_retire) begin
          r_count <= r_count + 1'b1;
        end else if (!w_alloc && w_retire) begin
          r_count <= r_count - 1'b1;
        end
      end
    end
  end

`ifdef BRQ_STATS_EN
  logic [31:0] r_stat_branches;
  logic [31:0] r_stat_mispredicts;

  assign stat_branches    = r_stat_branches;
  assign stat_mispredicts = r_stat_mispredicts;

  // A flush suppresses the retire in its cycle, so it must not be counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_branches    <= '0;
      r_stat_mispredicts <= '0;
    end else if (!flush && w_retire) begin
      if (r_stat_branches != '1) begin
        r_stat_branches <= r_stat_branches + 1'b1;
      end
      if (w_mispredict && (r_stat_mispredicts != '1)) begin
        r_stat_mispredicts <= r_stat_mispredicts + 1'b1;
      end
    end
  end
`endif

endmodule
